dct_mac_pipe: RTL and testbench

Parametrised, pipelined multiply-accumulate unit for the fdct_zigzag DCT datapath. It is the successor to the fixed-width per-unit mult_res/accumulator pair. It accepts a stream of signed sample/coefficient pairs, registers each product (mult_res stage) and accumulates ACC_LEN products. It then emits one scaled, saturated DCT coefficient per block, with valid/ready backpressure on both sides. One instance sits per dct_unit inside dct_block.

---
 rtl/dct_mac_pkg.sv | 35 +++
 rtl/dct_mac_sat.sv | 55 +++++
 rtl/dct_mac_pipe.sv | 91 +++++++++
 tb/tb_dct_mac_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_mac_pkg.sv
// Shared widths and helpers for the DCT multiply-accumulate datapath.
// Used by dct_mac_pipe and dct_mac_sat (which also serves the zigzag quantiser).
package dct_mac_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_COEF_W  = 12;
    localparam int DEF_ACC_LEN = 8;
    localparam int DEF_SHIFT   = 4;
    localparam int DEF_OUT_W   = 12;

    // Common signed width in which saturation decisions are made.
    localparam int SAT_W = 64;

    typedef logic signed [SAT_W-1:0] wide_t;

    // pos is meaningful only when ovf is set: 1 = clip to max, 0 = clip to min.
    typedef struct packed {
        logic ovf;
        logic pos;
    } sat_t;

    function automatic int acc_width(input int data_w, input int coef_w, input int acc_len);
        return data_w + coef_w + $clog2(acc_len);
    endfunction

    function automatic sat_t saturate(input wide_t s, input int out_w);
        sat_t  r;
        wide_t lim;
        lim   = wide_t'(1) <<< (out_w - 1);
        r.pos = (s >= lim);
        r.ovf = r.pos || (s < -lim);
        return r;
    endfunction

endpackage

// File: rtl/dct_mac_sat.sv
// Combinational scale / optional round / saturate stage.
// Define DCT_MAC_ROUND_EN for round-half-up before the shift; otherwise the shift truncates.
module dct_mac_sat
    import dct_mac_pkg::*;
#(
    parameter int IN_W  = DEF_DATA_W + DEF_COEF_W + 3,
    parameter int SHIFT = DEF_SHIFT,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic signed [IN_W-1:0]  sum,
    output logic signed [OUT_W-1:0] data,
    output logic                    ovf
);

`ifdef DCT_MAC_ROUND_EN
    // One extra bit so adding the half-LSB can never wrap.
    localparam int SC_W = IN_W + 1;

    logic signed [SC_W-1:0] half;
    logic signed [SC_W-1:0] rounded;
    logic signed [SC_W-1:0] scaled;

    always_comb begin
        half          = '0;
        half[SHIFT-1] = 1'b1;
    end

    assign rounded = $signed({sum[IN_W-1], sum}) + half;
    assign scaled  = rounded >>> SHIFT;
`else
    localparam int SC_W = IN_W;

    logic signed [SC_W-1:0] scaled;

    assign scaled = sum >>> SHIFT;
`endif

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    wide_t scaled_wide;
    sat_t  sat;

    assign scaled_wide = {{(SAT_W-SC_W){scaled[SC_W-1]}}, scaled};
    assign sat         = saturate(scaled_wide, OUT_W);
    assign ovf         = sat.ovf;

    always_comb begin
        data = scaled[OUT_W-1:0];
        if (sat.ovf) begin
            data = sat.pos ? OUT_MAX : OUT_MIN;
        end
    end

endmodule

// File: rtl/dct_mac_pipe.sv
// Pipelined signed MAC: registered product, ACC_LEN-deep accumulation, scaled saturated result.
// Rounding in the output stage is enabled by defining DCT_MAC_ROUND_EN.
module dct_mac_pipe
    import dct_mac_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COEF_W  = DEF_COEF_W,
    parameter int ACC_LEN = DEF_ACC_LEN,
    parameter int SHIFT   = DEF_SHIFT,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_W-1:0]     in_data,
    input  logic signed [COEF_W-1:0]     in_coef,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_W-1:0]      out_data,
    output logic                         out_ovf,
    output logic [$clog2(ACC_LEN)-1:0]   sample_cnt
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, ACC_LEN);
    localparam int CNT_W  = $clog2(ACC_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

    logic signed [PROD_W-1:0] mult_res;
    logic                     m_valid;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  final_sum;
    logic signed [OUT_W-1:0]  sat_data;
    logic                     sat_ovf;
    logic                     adv;

    // The whole pipeline freezes only while a result sits unaccepted.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    assign prod_ext  = {{(ACC_W-PROD_W){mult_res[PROD_W-1]}}, mult_res};
    assign final_sum = acc + prod_ext;

    dct_mac_sat #(
        .IN_W  (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_sat (
        .sum  (final_sum),
        .data (sat_data),
        .ovf  (sat_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_res   <= '0;
            m_valid    <= 1'b0;
            acc        <= '0;
            sample_cnt <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
        end else if (clr) begin
            m_valid    <= 1'b0;
            acc        <= '0;
            sample_cnt <= '0;
            out_valid  <= 1'b0;
        end else if (adv) begin
            mult_res <= PROD_W'(in_data) * PROD_W'(in_coef);
            m_valid  <= in_valid;
            // adv with out_valid set implies out_ready, so any held result transfers now.
            out_valid <= 1'b0;
            if (m_valid) begin
                if (sample_cnt == LAST) begin
                    out_data   <= sat_data;
                    out_ovf    <= sat_ovf;
                    out_valid  <= 1'b1;
                    acc        <= '0;
                    sample_cnt <= '0;
                end else begin
                    acc        <= final_sum;
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_mac_pipe.sv
// Self-checking bench for dct_mac_pipe: directed corner cases plus randomized traffic
// scored against a block-sum reference model.
module tb_dct_mac_pipe;

    localparam int DATA_W  = 8;
    localparam int COEF_W  = 12;
    localparam int ACC_LEN = 8;
    localparam int SHIFT   = 4;
    localparam int OUT_W   = 12;
    localparam int CNT_W   = $clog2(ACC_LEN);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     clr = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data = '0;
    logic signed [COEF_W-1:0] in_coef = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_ovf;
    logic [CNT_W-1:0]         sample_cnt;

    dct_mac_pipe #(
        .DATA_W (DATA_W), .COEF_W (COEF_W), .ACC_LEN (ACC_LEN),
        .SHIFT (SHIFT), .OUT_W (OUT_W)
    ) dut (
        .clk (clk), .rst_n (rst_n), .clr (clr),
        .in_valid (in_valid), .in_ready (in_ready),
        .in_data (in_data), .in_coef (in_coef),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_data (out_data), .out_ovf (out_ovf),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: accepted pairs collect into a block; a full block yields one result.
    typedef struct {
        longint data;
        bit     ovf;
    } res_t;

    longint blk_d[$];
    longint blk_c[$];
    res_t   exp_q[$];
    res_t   mon_r;

    function automatic res_t ref_block();
        longint sum = 0;
        longint s;
        longint lim;
        res_t   r;
        foreach (blk_d[i]) sum += blk_d[i] * blk_c[i];
`ifdef DCT_MAC_ROUND_EN
        s = (sum + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
`else
        s = sum >>> SHIFT;
`endif
        lim = longint'(1) <<< (OUT_W - 1);
        if (s > lim - 1) begin
            r.data = lim - 1; r.ovf = 1'b1;
        end else if (s < -lim) begin
            r.data = -lim; r.ovf = 1'b1;
        end else begin
            r.data = s; r.ovf = 1'b0;
        end
        return r;
    endfunction

    // Monitor on the falling edge: sees exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            blk_d.delete(); blk_c.delete(); exp_q.delete();
        end else if (clr) begin
            blk_d.delete(); blk_c.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_xfer++;
                check("out_expected", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_r = exp_q.pop_front();
                    check("out_data", out_data, mon_r.data);
                    check("out_ovf", out_ovf, longint'(mon_r.ovf));
                end
            end else if (out_valid && exp_q.size() > 0) begin
                check("held_data", out_data, exp_q[0].data);
            end
            if (in_valid && in_ready) begin
                blk_d.push_back(longint'(in_data));
                blk_c.push_back(longint'(in_coef));
                if (blk_d.size() == ACC_LEN) begin
                    exp_q.push_back(ref_block());
                    blk_d.delete(); blk_c.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input longint d, input longint c);
        int waited = 0;
        bit ok;
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        in_coef  = COEF_W'(c);
        do begin
            @(negedge clk);
            ok = in_ready;
            tick();
            waited++;
        end while (!ok && waited < 200);
        if (!ok) check("accept_timeout", longint'(ok), 1);
    endtask

    task automatic send_block(input int n, input longint d, input longint c);
        for (int i = 0; i < n; i++) send_pair(d, c);
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input longint d, input longint o);
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_ovf"}, out_ovf, o);
        tick();
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int xfer0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Basic block with latency and single-pulse checks.
        send_block(8, 1, 16);
        check("lat_t1_valid", out_valid, 0);
        tick();
        check("lat_t2_valid", out_valid, 1);
        check("basic_data", out_data, 8);
        check("basic_ovf", out_ovf, 0);
        tick();
        check("pulse_end_valid", out_valid, 0);

        send_block(8, 127, 2047);
        expect_result("sat_pos", 2047, 1);
        send_block(8, -128, 2047);
        expect_result("sat_neg", -2048, 1);

        send_block(8, 1, 1);
`ifdef DCT_MAC_ROUND_EN
        expect_result("round", 1, 0);
`else
        expect_result("trunc", 0, 0);
`endif

        // Backpressure: downstream stalls when the first of two results appears.
        out_ready = 1'b0;
        xfer0 = n_xfer;
        fork
            send_block(16, 1, 16);
            begin
                int w = 0;
                while (!out_valid && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                check("stall_seen", out_valid, 1);
                for (int i = 0; i < 5; i++) begin
                    check("stall_in_ready", in_ready, 0);
                    check("stall_hold", out_data, 8);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 20 && n_xfer < xfer0 + 2; i++) tick();
        check("stall_xfers", n_xfer - xfer0, 2);
        check("stall_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a block.
        send_block(3, 1, 16);
        tick(); tick();
        check("partial_cnt", sample_cnt, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_ovf", out_ovf, 0);
        check("arst_sample_cnt", sample_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        send_block(8, 1, 16);
        expect_result("post_rst", 8, 0);

        // Synchronous flush after a partial block.
        send_block(5, 1, 16);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_sample_cnt", sample_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clr_no_out", out_valid, 0);
        end
        send_block(8, 2, 16);
        expect_result("post_clr", 16, 0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = ($urandom_range(0, 7) == 0) ? DATA_W'(-128) : DATA_W'($urandom);
            in_coef   = ($urandom_range(0, 7) == 0) ? COEF_W'(2047) : COEF_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && (exp_q.size() > 0 || out_valid); i++) tick();
        tick(); tick();
        check("rand_drained", exp_q.size(), 0);
        check("rand_partial_cnt", sample_cnt, blk_d.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
